// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_BLANK   = 4'hF;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Inputs never exceed 9, so the 4-bit sum tops out at 12 without a carry.
    always_comb begin
        o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with optional leading-zero blanking.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W      = 8,
    parameter int unsigned DIGITS     = 3,
    parameter int unsigned LEAD_BLANK = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned     SCR_W   = BCD_DIGIT_W * DIGITS;
    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_BIN = (longint'(1) << BIN_W) - 1;

    generate
        if (!(pow10(DIGITS) > MAX_BIN)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small to hold 2**BIN_W - 1");
        end
    endgenerate

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_sh_bin;
    logic [SCR_W-1:0]   r_scratch;
    logic [SCR_W-1:0]   r_bcd;
    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_scr_nxt;
    logic [BIN_W-1:0]   w_sh_nxt;
    logic [SCR_W-1:0]   w_bcd_fmt;
    logic               w_last;
    logic               w_lead;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .i_digit (r_scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
                .o_digit (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_scr_nxt = {w_adj[SCR_W-2:0], r_sh_bin[BIN_W-1]};
    assign w_sh_nxt  = r_sh_bin << 1;
    assign w_last    = (r_cnt == CNT_W'(1));

    // Blank zeros from the top digit down until the first non-zero; ones digit always shown.
    always_comb begin
        w_bcd_fmt = w_scr_nxt;
        w_lead    = 1'b1;
        if (LEAD_BLANK != 0) begin
            for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
                if (w_lead && (w_scr_nxt[BCD_DIGIT_W*k +: BCD_DIGIT_W] == 4'd0)) begin
                    w_bcd_fmt[BCD_DIGIT_W*k +: BCD_DIGIT_W] = BCD_BLANK;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Result is loaded on the final shift so it is already visible during the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sh_bin  <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh_bin  <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    r_sh_bin  <= w_sh_nxt;
                    r_scratch <= w_scr_nxt;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bcd <= w_bcd_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and exhaustive checks of bin_to_bcd_seq, plain and with leading-zero blanking.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy0, done0, busy1, done1;
    logic [11:0] bcd0, bcd1;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .LEAD_BLANK(0)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy0),
        .done    (done0),
        .bcd_out (bcd0)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .LEAD_BLANK(1)) u_dut_blk (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy1),
        .done    (done1),
        .bcd_out (bcd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'(v / 100);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    function automatic logic [11:0] ref_blank(input int v);
        logic [11:0] b;
        b = ref_bcd(v);
        if (b[11:8] == 4'd0) begin
            b[11:8] = 4'hF;
            if (b[7:4] == 4'd0) b[7:4] = 4'hF;
        end
        return b;
    endfunction

    // Start on a negedge, then watch 12 edges; optionally re-assert start mid-conversion.
    task automatic run_conv(input string tag, input logic [7:0] v, input logic [11:0] e0,
                            input logic [11:0] e1, input int re_edge, input logic [7:0] re_val);
        int first, pulses;
        logic [11:0] got0, got1;
        first  = 0;
        pulses = 0;
        got0   = '0;
        got1   = '0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start  = 1'b0;
                bin_in = ~v;
            end
            if (re_edge != 0 && i == re_edge) begin
                start  = 1'b1;
                bin_in = re_val;
            end else if (re_edge != 0 && i == re_edge + 1) begin
                start = 1'b0;
            end
            if (done0) begin
                pulses++;
                if (first == 0) first = i;
                got0 = bcd0;
                got1 = bcd1;
            end
            if (i == 10) check({tag, "_busy_after"}, 32'(busy0), 32'd0);
        end
        check({tag, "_latency"}, 32'(first), 32'd9);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_bcd"}, 32'(got0), 32'(e0));
        check({tag, "_bcd_blk"}, 32'(got1), 32'(e1));
        check({tag, "_hold"}, 32'(bcd0), 32'(e0));
    endtask

    initial begin
        int pulses, v, prev;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy0), 32'd0);
            check("rst_done", 32'(done0), 32'd0);
            check("rst_bcd", 32'(bcd0), 32'h000);
            check("rst_bcd_blk", 32'(bcd1), 32'h000);
        end

        run_conv("c255", 8'd255, 12'h255, 12'h255, 0, 8'd0);
        run_conv("c7",   8'd7,   12'h007, 12'hFF7, 0, 8'd0);
        run_conv("c0",   8'd0,   12'h000, 12'hFF0, 0, 8'd0);
        run_conv("c100", 8'd100, 12'h100, 12'h100, 0, 8'd0);
        run_conv("c10",  8'd10,  12'h010, 12'hF10, 0, 8'd0);
        run_conv("ign",  8'd55,  12'h055, 12'hF55, 3, 8'd99);

        // Reset lands on the 4th edge of a conversion of 200.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd200;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 4) begin
                rst = 1'b0;
                check("abort_busy", 32'(busy0), 32'd0);
                check("abort_bcd", 32'(bcd0), 32'h000);
                check("abort_bcd_blk", 32'(bcd1), 32'h000);
            end
            if (done0 || done1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_conv("c42", 8'd42, 12'h042, 12'hF42, 0, 8'd0);

        // Exhaustive sweep with start held high so each conversion begins as early as allowed.
        @(negedge clk);
        v      = 0;
        prev   = 0;
        bin_in = 8'd0;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 3000 && v < 256; cyc++) begin
            @(negedge clk);
            if (done0) begin
                check("exh_bcd", 32'(bcd0), 32'(ref_bcd(v)));
                check("exh_bcd_blk", 32'(bcd1), 32'(ref_blank(v)));
                if (v > 0) check("exh_period", 32'(cyc - prev), 32'd10);
                prev = cyc;
                v++;
                bin_in = 8'(v);
                if (v == 256) start = 1'b0;
            end
        end
        start = 1'b0;
        check("exh_count", 32'(v), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
